// File: rtl/demux_tdm_pkg.sv
// rtl/demux_tdm_pkg.sv - shared types and constants for the 2:1 TDM demultiplexer
// Purpose: lock state enum, default word width and frame length helper.
package demux_tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // One frame carries one word per channel, bits interleaved.
  function automatic int frame_len(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/tdm_deser_lane.sv
// rtl/tdm_deser_lane.sv - one channel's serial-to-parallel word assembler
// Purpose: MSB-first shift register with clear and capture-to-output.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         shift din into the register this cycle
//   clr        discard the partial word; with en, din becomes the new first bit
//   cap        publish {shift[WIDTH-2:0], din} to dout this cycle
//   din        serial bit
//   dout       last published word
import demux_tdm_pkg::*;

module tdm_deser_lane #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             cap,
  input  logic             din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_in;

  // The word including the bit arriving this cycle, so capture needs no extra cycle.
  assign shift_in = {shift[WIDTH-2:0], din};

  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      dout  <= '0;
    end else begin
      if (clr) begin
        shift <= en ? {{(WIDTH-1){1'b0}}, din} : '0;
      end else if (en) begin
        shift <= shift_in;
      end
      if (cap) begin
        dout <= shift_in;
      end
    end
  end

endmodule

// File: rtl/demux2x1_tdm.sv
// rtl/demux2x1_tdm.sv - 2-channel bit-interleaved TDM demultiplexer with sync lock
// Purpose: locks to a frame sync, tracks the channel slot and reassembles
// one WIDTH-bit word per channel per frame.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   din, sync       serial interleaved data; sync marks ch0 MSB (frame position 0)
//   sel             slot of the bit sampled this cycle (0 while hunting)
//   locked          high while running
//   dout0, dout1    last completed word per channel
//   valid0, valid1  one-cycle strobes on word completion
//   err             one-cycle strobe: sync seen off position 0 while locked
import demux_tdm_pkg::*;

module demux2x1_tdm #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             sync,
  output logic             sel,
  output logic             locked,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic             valid0,
  output logic             valid1,
  output logic             err
);

  localparam int FL = frame_len(WIDTH);
  localparam int CW = $clog2(FL);
  localparam logic [CW-1:0] LAST0 = CW'(FL - 2);
  localparam logic [CW-1:0] LAST1 = CW'(FL - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load, resync;
  logic          en0, en1, cap0, cap1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    resync  = 1'b0;
    en0     = 1'b0;
    en1     = 1'b0;
    cap0    = 1'b0;
    cap1    = 1'b0;
    case (state)
      HUNT: begin
        if (sync) begin
          load    = 1'b1;
          en0     = 1'b1;
          cnt_n   = CW'(1);
          state_n = RUN;
        end
      end
      RUN: begin
        // A misplaced sync restarts the frame and suppresses any completion
        // that would have happened at this position.
        if (sync && cnt != '0) begin
          resync = 1'b1;
          load   = 1'b1;
          en0    = 1'b1;
          cnt_n  = CW'(1);
        end else begin
          en0   = ~cnt[0];
          en1   = cnt[0];
          cap0  = (cnt == LAST0);
          cap1  = (cnt == LAST1);
          cnt_n = cap1 ? '0 : cnt + CW'(1);
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      cnt    <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      valid0 <= cap0;
      valid1 <= cap1;
      err    <= resync;
    end
  end

  assign locked = (state == RUN);
  assign sel    = (state == RUN) & cnt[0];

  tdm_deser_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk  (clk),
    .rst  (rst),
    .en   (en0),
    .clr  (load),
    .cap  (cap0),
    .din  (din),
    .dout (dout0)
  );

  tdm_deser_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk  (clk),
    .rst  (rst),
    .en   (en1),
    .clr  (load),
    .cap  (cap1),
    .din  (din),
    .dout (dout1)
  );

endmodule

// File: tb/tb_demux2x1_tdm.sv
// tb/tb_demux2x1_tdm.sv - self-checking bench for demux2x1_tdm
module tb_demux2x1_tdm;

  localparam int W  = 8;
  localparam int FL = 2 * W;

  logic clk = 1'b0;
  logic rst, din, sync;
  logic sel, locked, valid0, valid1, err;
  logic [W-1:0] dout0, dout1;

  demux2x1_tdm #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .sync   (sync),
    .sel    (sel),
    .locked (locked),
    .dout0  (dout0),
    .dout1  (dout1),
    .valid0 (valid0),
    .valid1 (valid1),
    .err    (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame buffer indexed by position, words read out by channel.
  bit           m_locked = 1'b0;
  int           m_pos = 0;
  bit           m_bits [FL];
  logic [W-1:0] m_d0 = '0, m_d1 = '0;
  bit           m_v0 = 1'b0, m_v1 = 1'b0, m_err = 1'b0;

  logic [4+2*W:0] obs, expv;
  assign obs  = {locked, sel, valid0, valid1, err, dout0, dout1};
  assign expv = {m_locked, (m_locked ? m_pos[0] : 1'b0), m_v0, m_v1, m_err, m_d0, m_d1};

  bit [2:0]     stim [$];
  int           t0 [$], t1 [$], te [$];
  logic [W-1:0] d0q [$], d1q [$];

  function automatic logic [W-1:0] word_of(input int ch);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[W-1-i] = m_bits[2*i+ch];
    return w;
  endfunction

  function automatic bit frame_bit(input logic [W-1:0] a, input logic [W-1:0] b, input int p);
    logic [W-1:0] w;
    w = (p % 2 == 0) ? a : b;
    return w[W-1-p/2];
  endfunction

  task automatic model(input bit b, input bit s, input bit r);
    m_v0 = 1'b0; m_v1 = 1'b0; m_err = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_pos = 0; m_d0 = '0; m_d1 = '0;
    end else if (!m_locked) begin
      if (s) begin m_locked = 1'b1; m_bits[0] = b; m_pos = 1; end
    end else if (s && m_pos != 0) begin
      m_err = 1'b1; m_bits[0] = b; m_pos = 1;
    end else begin
      m_bits[m_pos] = b;
      if (m_pos == FL-2) begin m_d0 = word_of(0); m_v0 = 1'b1; end
      if (m_pos == FL-1) begin m_d1 = word_of(1); m_v1 = 1'b1; m_pos = 0; end
      else m_pos++;
    end
  endtask

  task automatic step(input bit b, input bit s, input bit r);
    @(negedge clk);
    din = b; sync = s; rst = r;
    @(posedge clk);
    model(b, s, r);
    #1;
  endtask

  task automatic push(input bit r, input bit b, input bit s);
    stim.push_back({r, b, s});
  endtask

  task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit s0, input int n);
    for (int p = 0; p < n; p++) push(1'b0, frame_bit(a, b, p % FL), (p == 0) && s0);
  endtask

  task automatic begin_test();
    stim.delete(); t0.delete(); t1.delete(); te.delete(); d0q.delete(); d1q.delete();
    push(1'b1, 1'b0, 1'b0);
  endtask

  task automatic note_events(input int k);
    if (valid0) begin t0.push_back(k); d0q.push_back(dout0); end
    if (valid1) begin t1.push_back(k); d1q.push_back(dout1); end
    if (err) te.push_back(k);
  endtask

  task automatic test_reset();
    begin_test();
    push(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) push(1'b0, i[0], 1'b0);
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k][1], stim[k][0], stim[k][2]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_idle k=%0d got=%h exp=%h", k, obs, expv); end
      if (k == 1) begin
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_state got=%h exp=0", obs); end
      end
    end
    checks++;
    if (locked !== 1'b0 || dout0 !== '0 || dout1 !== '0) begin
      errors++; $display("FAIL idle_no_lock got locked=%b d0=%h d1=%h exp 0/00/00", locked, dout0, dout1);
    end
  endtask

  task automatic test_single_frame();
    begin_test();
    push(1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    push_frame(8'hA5, 8'h3C, 1'b1, FL + 1);
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k][1], stim[k][0], stim[k][2]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL single_frame k=%0d got=%h exp=%h", k, obs, expv); end
      note_events(k);
    end
    checks++;
    if (t0.size() != 1 || t0[0] - 3 + 1 != 15 || d0q[0] !== 8'hA5) begin
      errors++; $display("FAIL single_v0 got n=%0d at=%0d d=%h exp 1/15/a5", t0.size(), t0[0] - 2, d0q[0]);
    end
    checks++;
    if (t1.size() != 1 || t1[0] - 3 + 1 != 16 || d1q[0] !== 8'h3C) begin
      errors++; $display("FAIL single_v1 got n=%0d at=%0d d=%h exp 1/16/3c", t1.size(), t1[0] - 2, d1q[0]);
    end
    checks++;
    if (te.size() != 0) begin errors++; $display("FAIL single_err got=%0d exp=0", te.size()); end
  endtask

  task automatic test_flywheel();
    logic [W-1:0] w0 [3];
    logic [W-1:0] w1 [3];
    w0 = '{8'h01, 8'hFF, 8'h5A};
    w1 = '{8'h80, 8'h00, 8'hC3};
    begin_test();
    for (int f = 0; f < 3; f++) push_frame(w0[f], w1[f], f == 0, FL);
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k][1], stim[k][0], stim[k][2]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL flywheel k=%0d got=%h exp=%h", k, obs, expv); end
      note_events(k);
    end
    checks++;
    if (t0.size() != 3 || t1.size() != 3) begin
      errors++; $display("FAIL fly_count got=%0d/%0d exp=3/3", t0.size(), t1.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (d0q[f] !== w0[f] || d1q[f] !== w1[f] || t0[f] != 15 + 16*f || t1[f] != 16 + 16*f) begin
          errors++;
          $display("FAIL fly_word%0d got=%h/%h at %0d/%0d exp=%h/%h at %0d/%0d",
                   f, d0q[f], d1q[f], t0[f], t1[f], w0[f], w1[f], 15 + 16*f, 16 + 16*f);
        end
      end
    end
  endtask

  task automatic test_resync_mid();
    begin_test();
    push_frame(8'h11, 8'h22, 1'b1, FL);
    push_frame(8'h77, 8'h66, 1'b0, 7);
    push_frame(8'h12, 8'h34, 1'b1, FL + 1);
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k][1], stim[k][0], stim[k][2]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL resync_mid k=%0d got=%h exp=%h", k, obs, expv); end
      note_events(k);
    end
    checks++;
    if (te.size() != 1 || te[0] != 24) begin
      errors++; $display("FAIL mid_err got n=%0d at=%0d exp 1 at 24", te.size(), te[0]);
    end
    checks++;
    if (t0.size() != 2 || t0[1] != 38 || t1.size() != 2 || t1[1] != 39) begin
      errors++; $display("FAIL mid_valid got n=%0d/%0d exp 2/2 at 38/39", t0.size(), t1.size());
    end
    checks++;
    if (dout0 !== 8'h12 || dout1 !== 8'h34) begin
      errors++; $display("FAIL mid_words got=%h/%h exp=12/34", dout0, dout1);
    end
  endtask

  task automatic test_resync_last();
    begin_test();
    push_frame(8'h11, 8'h22, 1'b1, FL);
    push_frame(8'h77, 8'h66, 1'b0, FL - 2);
    push_frame(8'hA5, 8'h3C, 1'b1, FL + 1);
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k][1], stim[k][0], stim[k][2]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL resync_last k=%0d got=%h exp=%h", k, obs, expv); end
      note_events(k);
    end
    checks++;
    if (te.size() != 1 || te[0] != 31) begin
      errors++; $display("FAIL last_err got n=%0d at=%0d exp 1 at 31", te.size(), te[0]);
    end
    checks++;
    if (t0.size() != 2 || t0[0] != 15 || t0[1] != 45) begin
      errors++; $display("FAIL last_v0 got n=%0d at=%0d exp 2 at 15,45", t0.size(), t0[1]);
    end
    checks++;
    if (dout0 !== 8'hA5 || dout1 !== 8'h3C) begin
      errors++; $display("FAIL last_words got=%h/%h exp=a5/3c", dout0, dout1);
    end
  endtask

  task automatic test_reset_mid();
    begin_test();
    push_frame(8'h11, 8'h22, 1'b1, 9);
    push(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b0);
    push_frame(8'hA5, 8'h3C, 1'b1, FL);
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k][1], stim[k][0], stim[k][2]);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs, expv); end
      if (k == 10) begin
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_mid_zero got=%h exp=0", obs); end
      end
      note_events(k);
    end
    checks++;
    if (t0.size() != 1 || t0[0] != 28 || t1.size() != 1 || t1[0] != 29) begin
      errors++; $display("FAIL rmid_valid got n=%0d/%0d exp 1/1 at 28/29", t0.size(), t1.size());
    end
    checks++;
    if (dout0 !== 8'hA5 || dout1 !== 8'h3C) begin
      errors++; $display("FAIL rmid_words got=%h/%h exp=a5/3c", dout0, dout1);
    end
  endtask

  task automatic test_random();
    bit b, s, r;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 600; k++) begin
      b = 1'($urandom);
      if (m_locked && m_pos == 0) s = ($urandom_range(0, 3) != 0);
      else s = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(b, s, r);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, expv); end
      checks++;
      if (valid0 && valid1) begin errors++; $display("FAIL random_both_valid k=%0d got=11 exp=not both", k); end
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; sync = 1'b0;
    test_reset();
    test_single_frame();
    test_flywheel();
    test_resync_mid();
    test_resync_last();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
